// File: rtl/pc_seq_cu.sv
// rtl/pc_seq_cu.sv - program counter sequencing control unit
// Ports:
//   clk, reset (async, active-low)
//   intr_req/intr_mask : per-channel interrupt requests and enables
//   mem_ready, ilen    : fetch handshake and predecoded instruction length
//   opcode, brx, flags : decoded fields and ALU flags used in DONE
//   pc_en, pc_load, pc_src, vec_idx : PC write control
//   byte_sel, if_en    : instruction byte fetch request
//   instr_done, intr_ack, ie : completion pulse, interrupt acknowledge, enable status
module pc_seq_cu #(
   parameter int NVEC = 4,
   parameter int MAXB = 3,
   parameter int VW   = 3,
   parameter int BW   = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NVEC-1:0] intr_req,
   input  logic [NVEC-1:0] intr_mask,
   input  logic            mem_ready,
   input  logic [BW:0]     ilen,
   input  logic [3:0]      opcode,
   input  logic [1:0]      brx,
   input  logic            z_flag,
   input  logic            n_flag,
   input  logic            c_flag,
   input  logic            v_flag,
   output logic            pc_en,
   output logic            pc_load,
   output logic [1:0]      pc_src,
   output logic [VW-1:0]   vec_idx,
   output logic [BW-1:0]   byte_sel,
   output logic            if_en,
   output logic            instr_done,
   output logic [NVEC-1:0] intr_ack,
   output logic            ie
);

   typedef enum logic [2:0] {RESET, FETCH, FETCHX, DONE, INTR} state_t;

   state_t          state, state_nx;
   logic            ie_q;
   logic [BW:0]     len_q;
   logic [BW-1:0]   cnt;
   logic [VW-1:0]   w_q;

   logic [NVEC-1:0] active;
   logic            pend;
   logic [VW-1:0]   win;
   logic [BW:0]     eff_len;
   logic            last_byte;
   logic            br_flag;

   assign active = intr_req & intr_mask;
   assign pend   = ie_q & (|active);
   assign ie     = ie_q;

   // Lowest index wins: scan from the top so the lowest set bit is written last.
   always_comb begin
      win = '0;
      for (int k = NVEC - 1; k >= 0; k--) begin
         if (active[k]) win = VW'(k);
      end
   end

   // Out-of-range lengths degrade to a single-byte instruction.
   assign eff_len = (ilen != '0 && ilen <= (BW+1)'(MAXB)) ? ilen : (BW+1)'(1);

   assign last_byte = ({1'b0, cnt} == (len_q - (BW+1)'(1)));

   always_comb begin
      case (brx)
         2'd0:    br_flag = z_flag;
         2'd1:    br_flag = n_flag;
         2'd2:    br_flag = c_flag;
         default: br_flag = v_flag;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RESET;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      pc_en      = 1'b0;
      pc_load    = 1'b0;
      pc_src     = 2'b00;
      vec_idx    = '0;
      byte_sel   = '0;
      if_en      = 1'b0;
      instr_done = 1'b0;
      intr_ack   = '0;
      case (state)
         RESET: begin
            pc_en    = 1'b1;
            pc_load  = 1'b1;
            state_nx = FETCH;
         end
         FETCH: begin
            // A pending interrupt pre-empts the fetch even when memory is ready.
            if (pend) begin
               state_nx = INTR;
            end else begin
               if_en = 1'b1;
               if (mem_ready) begin
                  pc_en    = 1'b1;
                  state_nx = (eff_len == (BW+1)'(1)) ? DONE : FETCHX;
               end
            end
         end
         FETCHX: begin
            if_en    = 1'b1;
            byte_sel = cnt;
            if (mem_ready) begin
               pc_en = 1'b1;
               if (last_byte) state_nx = DONE;
            end
         end
         DONE: begin
            instr_done = 1'b1;
            state_nx   = FETCH;
            case (opcode)
               4'd9: begin
                  if (br_flag) begin
                     pc_en   = 1'b1;
                     pc_load = 1'b1;
                     pc_src  = 2'b10;
                  end
               end
               4'd10: begin
                  if (!z_flag) begin
                     pc_en   = 1'b1;
                     pc_load = 1'b1;
                     pc_src  = 2'b10;
                  end
               end
               4'd11: begin
                  pc_en   = 1'b1;
                  pc_load = 1'b1;
                  pc_src  = brx[1] ? 2'b11 : 2'b10;
               end
               default: ;
            endcase
         end
         INTR: begin
            pc_en    = 1'b1;
            pc_load  = 1'b1;
            vec_idx  = w_q + VW'(1);
            intr_ack = NVEC'(1) << w_q;
            state_nx = FETCH;
         end
         default: state_nx = RESET;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ie_q  <= 1'b1;
         len_q <= (BW+1)'(1);
         cnt   <= '0;
         w_q   <= '0;
      end else begin
         case (state)
            FETCH: begin
               // Winner is frozen here so request changes during INTR are ignored.
               if (pend) begin
                  w_q <= win;
               end else if (mem_ready) begin
                  len_q <= eff_len;
                  cnt   <= BW'(1);
               end
            end
            FETCHX: begin
               if (mem_ready) cnt <= cnt + BW'(1);
            end
            DONE: begin
               if (opcode == 4'd11 && brx == 2'd3) ie_q <= 1'b1;
            end
            INTR: begin
               ie_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/pc_seq_cu.md
PC_SEQ_CU -- requirements
Module: pc_seq_cu

Interface
REQ-001 Parameter NVEC, default 4: number of maskable interrupt channels, 1..7.
REQ-002 Parameter MAXB, default 3: maximum instruction length in bytes, 2..4.
REQ-003 Parameter VW, default 3: vector index width; SHALL satisfy 2^VW > NVEC.
REQ-004 Parameter BW, default 2: byte index width; SHALL satisfy 2^BW >= MAXB.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 intr_req  in  NVEC  level interrupt requests, one per channel.
REQ-008 intr_mask  in  NVEC  per-channel enable; 1 = enabled.
REQ-009 mem_ready  in  1  fetch handshake; the byte on the instruction bus is accepted in any cycle with if_en=1 and mem_ready=1.
REQ-010 ilen  in  BW+1  predecoded length (1..MAXB) of the byte currently on the instruction bus; valid in FETCH.
REQ-011 opcode  in  4, brx  in  2  decoded instruction fields; stable in DONE.
REQ-012 z_flag, n_flag, c_flag, v_flag  in  1 each  ALU flags.
REQ-013 pc_en  out  1  PC write enable; increments the PC when pc_load=0.
REQ-014 pc_load  out  1  selects a load of the PC from pc_src instead of an increment.
REQ-015 pc_src  out  2  load source: 00 = M[vec_idx], 10 = R[rb], 11 = stack.
REQ-016 vec_idx  out  VW  vector table index; 0 = reset, k+1 = interrupt channel k.
REQ-017 byte_sel  out  BW  index of the instruction byte being fetched.
REQ-018 if_en  out  1  instruction fetch request.
REQ-019 instr_done  out  1  one-cycle pulse at instruction completion.
REQ-020 intr_ack  out  NVEC  one-hot, one-cycle acknowledge of the serviced channel.
REQ-021 ie  out  1  global interrupt enable status.

Function
REQ-022 The FSM SHALL have exactly these states: RESET, FETCH, FETCHX, DONE, INTR.
REQ-023 pend = ie & |(intr_req & intr_mask); the winning channel w is the lowest set index.
REQ-024 RESET: pc_en=1, pc_load=1, pc_src=00, vec_idx=0; next state FETCH on the first clock edge after reset release.
REQ-025 FETCH, pend=1: no fetch (if_en=0, pc_en=0); next state INTR; interrupt wins even if mem_ready=1.
REQ-026 FETCH, pend=0: if_en=1, byte_sel=0; if mem_ready=0, hold all outputs and stay in FETCH (no PC increment).
REQ-027 FETCH accept: pc_en=1, pc_load=0; latch len_q=ilen and set cnt=1; next state DONE if ilen=1, else FETCHX.
REQ-028 FETCHX: if_en=1, byte_sel=cnt; pc_en=1 only on accept; on accept cnt increments; when the accepted byte has cnt=len_q-1, next state DONE.
REQ-029 Interrupts SHALL NOT be taken in FETCHX or DONE; a multi-byte instruction always completes.
REQ-030 ilen outside 1..MAXB SHALL be treated as 1.
REQ-031 DONE: instr_done=1; next state FETCH unconditionally.
REQ-032 DONE PC decision, otherwise no PC write:
  - opcode 9: brx 0/1/2/3 selects Z/N/C/V; if set, pc_en=pc_load=1, pc_src=10.
  - opcode 10, z_flag=0: pc_en=pc_load=1, pc_src=10.
  - opcode 11, brx<2: pc_en=pc_load=1, pc_src=10.
  - opcode 11, brx>=2: pc_en=pc_load=1, pc_src=11.
REQ-033 RTI (opcode 11, brx=3) SHALL set ie=1 at the end of DONE.
REQ-034 INTR (exactly one cycle): pc_en=pc_load=1, pc_src=00, vec_idx=w+1, intr_ack[w]=1; ie cleared at the end of the cycle; next state FETCH.
REQ-035 w SHALL be registered on FETCH->INTR; request changes during INTR SHALL NOT alter vec_idx or intr_ack.
REQ-036 Unlisted outputs in any state SHALL be 0.

Reset
REQ-037 Asserting reset low in any state SHALL immediately force state=RESET, ie=1, len_q=1, cnt=0, registered w=0.
REQ-038 While reset is low, outputs SHALL be: pc_en=1, pc_load=1, pc_src=00, vec_idx=0, all others 0.
REQ-039 Reset asserted mid-FETCHX or mid-INTR SHALL abandon the operation with no intr_ack or instr_done.

Verification
REQ-040 Release reset, mem_ready=1, ilen=1, opcode=0 -> RESET, FETCH, DONE, FETCH; one pc_en per byte; instr_done every second cycle.
REQ-041 ilen=3 with mem_ready low for 2 cycles on byte 1 -> byte_sel 0,1,1,1,2; exactly 3 pc_en pulses; instr_done after byte 2.
REQ-042 intr_req=0110, intr_mask=1111, ie=1 in FETCH -> INTR with vec_idx=2, intr_ack=0010, ie=0; no re-entry until RTI.
REQ-043 intr_req rises during FETCHX of a 3-byte instruction -> instruction completes with instr_done, then INTR.
REQ-044 DONE with opcode 9, brx=2, c_flag=1 -> pc_load=1, pc_src=10; same with c_flag=0 -> no PC write.
REQ-045 Reset low mid-FETCHX -> outputs immediately match REQ-038; after release, fetch restarts at byte_sel=0.
